i2c_channel_sequencer: RTL and testbench
========================================

I2C_CHANNEL_SEQUENCER -- requirements
Module: i2c_channel_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4: number of module I2C channels behind the host bus mux.
REQ-002 Parameter GUARD_CYCLES, default 8: disconnect-to-connect dead time, in clk cycles.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum continuous scl-low time while BUSY before forced release.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_channel  in  3  requested module channel; a value >= CHANNELS means "none".
REQ-007 sda_in  in  1  host bus SDA level (asynchronous, open-drain resolved).
REQ-008 scl_in  in  1  host bus SCL level (asynchronous, open-drain resolved).
REQ-009 sel_valid  out  1  mux enable; high = host bus connected to sel_channel.
REQ-010 sel_channel  out  2  connected channel index; meaningful only when sel_valid=1.
REQ-011 busy  out  1  high while a transaction (START seen, STOP not yet seen) is in progress.
REQ-012 switch_done  out  1  one-cycle pulse when a new connection becomes valid.
REQ-013 timeout  out  1  one-cycle pulse on forced release from BUSY.

Function
REQ-014 sda_in/scl_in SHALL each pass a 2-flop synchronizer, then one history register; START = sda 1->0 with scl=1, STOP = sda 0->1 with scl=1, both on synchronized values; detection latency 3 cycles from pin.
REQ-015 FSM states IDLE, GUARD, CONNECTED, BUSY; sel_valid=1 only in CONNECTED and BUSY.
REQ-016 IDLE: req_channel < CHANNELS -> GUARD, pending <= req_channel, counter <= GUARD_CYCLES-1.
REQ-017 GUARD: counter decrements each cycle; at 0 -> CONNECTED, sel_channel <= pending, switch_done=1 for that transition cycle.
REQ-018 GUARD: req_channel changes to another valid channel -> pending updated, counter reloaded; changes to "none" -> IDLE.
REQ-019 CONNECTED: START -> BUSY; else req_channel != sel_channel -> sel_valid drops next cycle, state -> GUARD (valid request) or IDLE ("none").
REQ-020 CONNECTED: START and request change in same cycle -> START wins (BUSY); request re-evaluated after STOP.
REQ-021 BUSY: request changes SHALL be ignored; STOP -> CONNECTED.
REQ-022 BUSY: repeated START SHALL keep BUSY and clear the timeout counter.
REQ-023 BUSY: timeout counter counts cycles with synchronized scl=0, clears when scl=1; reaching TIMEOUT_CYCLES-1 -> timeout pulse, state CONNECTED.
REQ-024 Counters SHALL saturate, never wrap; widths $clog2 of their parameter.
REQ-025 Bus activity in IDLE/GUARD SHALL be ignored (no state change).

Reset
REQ-026 reset=1 -> state IDLE, sel_valid=0, sel_channel=0, busy=0, switch_done=0, timeout=0, counters 0, synchronizers/history at 1 (idle bus).
REQ-027 reset mid-BUSY SHALL disconnect on the next clk edge without waiting for STOP.

Structure
REQ-028 State encoding and default parameter constants SHALL live in a shared package device_handler_pkg.
REQ-029 START/STOP detection incl. synchronizers SHALL be a sub-module i2c_cond_detect (outputs start, stop, scl_s).

Verification
REQ-030 reset 10 cycles, req_channel=1 -> sel_valid rises exactly 8 cycles after leaving IDLE, sel_channel=1, switch_done single pulse.
REQ-031 connected ch1, START, then req_channel=2 mid-transaction -> stays ch1, busy=1; STOP -> 3 cycles later busy=0, sel_valid drops, ch2 valid 8 cycles after.
REQ-032 connected ch0, req_channel=7 -> sel_valid=0 next cycle, state IDLE, no switch_done.
REQ-033 BUSY with scl held low 1024 cycles -> timeout pulse once, busy=0, sel_valid stays 1.
REQ-034 GUARD toward ch2, req changed to ch3 at counter=3 -> connection to ch3 only, 8 cycles after change.
REQ-035 START and req change in same cycle, then reset asserted in BUSY -> BUSY entered; after reset all outputs 0 next edge.

Source files
------------

// File: rtl/device_handler_pkg.sv
// Shared state encoding and default sizing for the I2C channel sequencer.
package device_handler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GUARD     = 2'd1,
      ST_CONNECTED = 2'd2,
      ST_BUSY      = 2'd3
   } state_e;

   localparam int DEF_CHANNELS       = 4;
   localparam int DEF_GUARD_CYCLES   = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Counter width for a cycle count, never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Synchronises the host SDA/SCL pins and flags START/STOP conditions on the
// synchronised levels, using one extra history stage for edge detection.
module i2c_cond_detect (
   input  logic clk,
   input  logic reset,
   input  logic sda_in,
   input  logic scl_in,
   output logic start,
   output logic stop,
   output logic scl_s
);

   logic [1:0] sda_sync_q;
   logic [1:0] scl_sync_q;
   logic       sda_hist_q;
   logic       scl_hist_q;

   // Synchroniser chains and history stage; reset to an idle (high) bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         sda_sync_q <= 2'b11;
         scl_sync_q <= 2'b11;
         sda_hist_q <= 1'b1;
         scl_hist_q <= 1'b1;
      end else begin
         sda_sync_q <= {sda_sync_q[0], sda_in};
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_hist_q <= sda_sync_q[1];
         scl_hist_q <= scl_sync_q[1];
      end
   end

   assign start = sda_hist_q & ~sda_sync_q[1] & scl_sync_q[1];
   assign stop  = ~sda_hist_q & sda_sync_q[1] & scl_sync_q[1];
   assign scl_s = scl_sync_q[1];

   logic unused_s;
   assign unused_s = scl_hist_q;

endmodule

// File: rtl/i2c_channel_sequencer.sv
// Connects the host I2C bus to one module channel at a time, with a dead-time
// guard between connections and no switching while a transaction is open.
module i2c_channel_sequencer
   import device_handler_pkg::*;
#(
   parameter int CHANNELS       = DEF_CHANNELS,
   parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req_channel,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       sel_valid,
   output logic [1:0] sel_channel,
   output logic       busy,
   output logic       switch_done,
   output logic       timeout
);

   localparam int GW = cnt_width(GUARD_CYCLES);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [1:0]    pending_q, pending_d;
   logic [1:0]    sel_channel_q, sel_channel_d;
   logic          sel_valid_q, sel_valid_d;
   logic          busy_q, busy_d;
   logic          switch_done_q, switch_done_d;
   logic          timeout_q, timeout_d;

   logic          start_s, stop_s, scl_s;
   logic          req_valid_s;
   logic [1:0]    req_idx_s;

   i2c_cond_detect u_cond (
      .clk    (clk),
      .reset  (reset),
      .sda_in (sda_in),
      .scl_in (scl_in),
      .start  (start_s),
      .stop   (stop_s),
      .scl_s  (scl_s)
   );

   assign req_valid_s = ({29'd0, req_channel} < CHANNELS[31:0]);
   assign req_idx_s   = req_channel[1:0];

   // Next-state and counter logic for the connection FSM.
   always_comb begin
      state_d       = state_q;
      gcnt_d        = gcnt_q;
      tcnt_d        = tcnt_q;
      pending_d     = pending_q;
      sel_channel_d = sel_channel_q;
      switch_done_d = 1'b0;
      timeout_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_s) begin
               state_d   = ST_GUARD;
               pending_d = req_idx_s;
               gcnt_d    = GUARD_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GUARD: begin
            if (!req_valid_s) begin
               state_d = ST_IDLE;
               gcnt_d  = {GW{1'b0}};
            end else if (req_idx_s != pending_q) begin
               pending_d = req_idx_s;
               gcnt_d    = GUARD_LOAD;
            end else if (gcnt_q == {GW{1'b0}}) begin
               state_d       = ST_CONNECTED;
               sel_channel_d = pending_q;
               switch_done_d = 1'b1;
            end else begin
               gcnt_d = gcnt_q - GW'(1);
            end
         end
         ST_CONNECTED: begin
            // A START in the same cycle as a request change takes priority.
            if (start_s) begin
               state_d = ST_BUSY;
               tcnt_d  = {TW{1'b0}};
            end else if (req_channel != {1'b0, sel_channel_q}) begin
               if (req_valid_s) begin
                  state_d   = ST_GUARD;
                  pending_d = req_idx_s;
                  gcnt_d    = GUARD_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_CONNECTED;
            end
         end
         ST_BUSY: begin
            if (stop_s) begin
               state_d = ST_CONNECTED;
               tcnt_d  = {TW{1'b0}};
            end else if (start_s) begin
               tcnt_d = {TW{1'b0}};
            end else if (!scl_s) begin
               if (tcnt_q == TO_LAST) begin
                  state_d   = ST_CONNECTED;
                  timeout_d = 1'b1;
                  tcnt_d    = {TW{1'b0}};
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end else begin
               tcnt_d = {TW{1'b0}};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      sel_valid_d = (state_d == ST_CONNECTED) || (state_d == ST_BUSY);
      busy_d      = (state_d == ST_BUSY);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         gcnt_q        <= {GW{1'b0}};
         tcnt_q        <= {TW{1'b0}};
         pending_q     <= 2'd0;
         sel_channel_q <= 2'd0;
         sel_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         switch_done_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         gcnt_q        <= gcnt_d;
         tcnt_q        <= tcnt_d;
         pending_q     <= pending_d;
         sel_channel_q <= sel_channel_d;
         sel_valid_q   <= sel_valid_d;
         busy_q        <= busy_d;
         switch_done_q <= switch_done_d;
         timeout_q     <= timeout_d;
      end
   end

   assign sel_valid   = sel_valid_q;
   assign sel_channel = sel_channel_q;
   assign busy        = busy_q;
   assign switch_done = switch_done_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_i2c_channel_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a pin-history reference model of the sequencer behaviour.
module tb_i2c_channel_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] req_channel = 3'd7;
   logic       sda_in = 1'b1;
   logic       scl_in = 1'b1;
   logic       sel_valid;
   logic [1:0] sel_channel;
   logic       busy;
   logic       switch_done;
   logic       timeout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2c_channel_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .req_channel (req_channel),
      .sda_in      (sda_in),
      .scl_in      (scl_in),
      .sel_valid   (sel_valid),
      .sel_channel (sel_channel),
      .busy        (busy),
      .switch_done (switch_done),
      .timeout     (timeout)
   );

   logic [5:0] dut_vec;
   assign dut_vec = {sel_valid, sel_channel, busy, switch_done, timeout};

   // Reference model. Modes: 0 off, 1 waiting dead time, 2 connected, 3 in transaction.
   // Pin samples: p[0] taken one edge ago, p[1] two edges ago, p[2] three edges ago.
   int         m_mode = 0, m_remain = 0, m_target = 0, m_ch = 0, m_low = 0;
   bit         m_sd = 1'b0, m_to = 1'b0;
   bit         sda_p [3] = '{1'b1, 1'b1, 1'b1};
   bit         scl_p [3] = '{1'b1, 1'b1, 1'b1};
   logic [5:0] exp_vec = 6'd0;

   always @(posedge clk) begin
      bit st, sp, ok;
      m_sd = 1'b0;
      m_to = 1'b0;
      if (reset) begin
         m_mode = 0; m_remain = 0; m_target = 0; m_ch = 0; m_low = 0;
         for (int k = 0; k < 3; k++) begin
            sda_p[k] = 1'b1;
            scl_p[k] = 1'b1;
         end
      end else begin
         st = sda_p[2] && !sda_p[1] && scl_p[1];
         sp = !sda_p[2] && sda_p[1] && scl_p[1];
         ok = (int'(req_channel) < 4);
         if (m_mode == 0) begin
            if (ok) begin m_mode = 1; m_target = int'(req_channel); m_remain = 7; end
         end else if (m_mode == 1) begin
            if (!ok) m_mode = 0;
            else if (int'(req_channel) != m_target) begin m_target = int'(req_channel); m_remain = 7; end
            else if (m_remain == 0) begin m_mode = 2; m_ch = m_target; m_sd = 1'b1; end
            else m_remain = m_remain - 1;
         end else if (m_mode == 2) begin
            if (st) begin m_mode = 3; m_low = 0; end
            else if (int'(req_channel) != m_ch) begin
               if (ok) begin m_mode = 1; m_target = int'(req_channel); m_remain = 7; end
               else m_mode = 0;
            end
         end else begin
            if (sp) m_mode = 2;
            else if (st) m_low = 0;
            else if (!scl_p[1]) begin
               if (m_low == 1023) begin m_mode = 2; m_to = 1'b1; end
               else m_low = m_low + 1;
            end else m_low = 0;
         end
         sda_p[2] = sda_p[1]; sda_p[1] = sda_p[0]; sda_p[0] = sda_in;
         scl_p[2] = scl_p[1]; scl_p[1] = scl_p[0]; scl_p[0] = scl_in;
      end
      exp_vec = {(m_mode >= 2), 2'(m_ch), (m_mode == 3), m_sd, m_to};
   end

   task automatic do_reset();
      reset = 1'b1; sda_in = 1'b1; scl_in = 1'b1; req_channel = 3'd7;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req_channel = 3'($urandom_range(0, 7));
      for (int i = 1; i <= 10; i++) begin
         sda_in = 1'($urandom); scl_in = 1'($urandom);
         @(negedge clk);
         n_vec++;
         if (dut_vec !== 6'b000000) begin
            n_err++;
            $display("FAIL reset cyc %0d: got %b expected 000000", i, dut_vec);
         end
      end
      sda_in = 1'b1; scl_in = 1'b1;
      do_reset();
   endtask

   task automatic test_connect();
      do_reset();
      req_channel = 3'd1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec) begin
            n_err++; $display("FAIL connect_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
         n_vec++;
         if (sel_valid !== (i >= 9) || switch_done !== (i == 9) || (i >= 9 && sel_channel !== 2'd1)) begin
            n_err++; $display("FAIL connect_timing cyc %0d: got v=%b sd=%b ch=%0d", i, sel_valid, switch_done, sel_channel);
         end
      end
   endtask

   task automatic test_busy_hold();
      do_reset();
      req_channel = 3'd1;
      repeat (9) @(negedge clk);
      sda_in = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL busy_enter: got busy=%b expected 1", busy);
      end
      req_channel = 3'd2;
      for (int i = 1; i <= 8; i++) begin
         scl_in = (i > 4);
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec || {sel_valid, sel_channel, busy} !== 4'b1011) begin
            n_err++; $display("FAIL busy_hold cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
      end
      sda_in = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec || busy !== (i < 3) || sel_valid !== (i < 4 || i >= 12)
             || switch_done !== (i == 12) || (i >= 12 && sel_channel !== 2'd2)) begin
            n_err++; $display("FAIL busy_release cyc %0d: got %b model %b", i, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_none();
      do_reset();
      req_channel = 3'd0;
      repeat (9) @(negedge clk);
      n_vec++;
      if (sel_valid !== 1'b1 || sel_channel !== 2'd0) begin
         n_err++; $display("FAIL none_connect: got v=%b ch=%0d expected v=1 ch=0", sel_valid, sel_channel);
      end
      req_channel = 3'd7;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec || sel_valid !== 1'b0 || switch_done !== 1'b0) begin
            n_err++; $display("FAIL none_drop cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int at = 0;
      do_reset();
      req_channel = 3'd1;
      repeat (9) @(negedge clk);
      sda_in = 1'b0;
      repeat (3) @(negedge clk);
      scl_in = 1'b0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec) begin
            n_err++; $display("FAIL timeout_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
         if (timeout === 1'b1) begin pulses++; at = i; end
      end
      n_vec++;
      if (pulses != 1 || at != 1026 || busy !== 1'b0 || sel_valid !== 1'b1) begin
         n_err++; $display("FAIL timeout_pulse: got %0d pulses at %0d busy=%b v=%b expected 1 at 1026 busy=0 v=1",
                           pulses, at, busy, sel_valid);
      end
      scl_in = 1'b1;
      repeat (3) @(negedge clk);
      sda_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_retarget();
      do_reset();
      req_channel = 3'd2;
      repeat (5) @(negedge clk);
      req_channel = 3'd3;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec || sel_valid !== (i >= 9) || switch_done !== (i == 9)
             || (i >= 9 && sel_channel !== 2'd3)) begin
            n_err++; $display("FAIL retarget cyc %0d: got %b model %b", i, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_start_req_reset();
      do_reset();
      req_channel = 3'd1;
      repeat (9) @(negedge clk);
      sda_in = 1'b0;
      repeat (2) @(negedge clk);
      req_channel = 3'd2;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec || {sel_valid, sel_channel, busy} !== 4'b1011) begin
            n_err++; $display("FAIL start_wins cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
      end
      reset = 1'b1; sda_in = 1'b1; req_channel = 3'd7;
      @(negedge clk);
      n_vec++;
      if (dut_vec !== 6'b000000) begin
         n_err++; $display("FAIL busy_reset: got %b expected 000000", dut_vec);
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 1; i <= 4000; i++) begin
         if ($urandom_range(0, 19) == 0) req_channel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) sda_in = ~sda_in;
         if ($urandom_range(0, 5) == 0) scl_in = ~scl_in;
         reset = ($urandom_range(0, 499) == 0);
         @(negedge clk);
         n_vec++;
         if (dut_vec !== exp_vec) begin
            n_err++; $display("FAIL random cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_connect();
      test_busy_hold();
      test_none();
      test_timeout();
      test_retarget();
      test_start_req_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
